// File: rtl/mem_pkg.sv
// Shared address map, access-size encoding and helpers for the memory responder.
package mem_pkg;

   localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0;
   localparam logic [31:0] MMIO_LED    = 32'hFFFF_FFF0;
   localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;
   localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;

   function automatic int unsigned us_divisor(input int unsigned clk_hz);
      return (clk_hz < 1_000_000) ? 1 : clk_hz / 1_000_000;
   endfunction

   // Select and extend a byte/halfword from a word; unknown sizes return the full word.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {off, 3'b000});
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/mmio_timebase.sv
// Free-running microsecond prescaler with micros and millis counters.
module mmio_timebase
   import mem_pkg::*;
#(
   parameter int unsigned CLK_HZ = 12_000_000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        us_tick,
   output logic [31:0] micros,
   output logic [31:0] millis
);

   localparam int unsigned DIV = us_divisor(CLK_HZ);

   logic [31:0] us_prescale;
   logic [9:0]  ms_count;

   always_comb us_tick = (us_prescale == 32'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         us_prescale <= '0;
         micros      <= '0;
         ms_count    <= '0;
         millis      <= '0;
      end else if (us_tick) begin
         us_prescale <= '0;
         micros      <= micros + 32'd1;
         if (ms_count == 10'd999) begin
            ms_count <= '0;
            millis   <= millis + 32'd1;
         end else begin
            ms_count <= ms_count + 10'd1;
         end
      end else begin
         us_prescale <= us_prescale + 32'd1;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Unified RAM plus LED/timer MMIO page behind the core's shared memory port.
// Reads are one-cycle latency, read-before-write; stores use byte-lane enables.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 2048,
  parameter string       INIT_FILE = "",
  parameter int unsigned CLK_HZ    = 12_000_000,
  parameter int unsigned PWM_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        misaligned,
  output logic [3:0]  leds
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [7:0]  DUTY_MASK = 8'((1 << PWM_BITS) - 1);

  logic [31:0]         ram [MEM_WORDS];
  logic [31:0]         led_reg;
  logic [31:0]         micros;
  logic [31:0]         millis;
  logic [PWM_BITS-1:0] pwm_cnt;

  logic [AW-1:0] idx;
  logic          in_ram, in_mmio, is_led, is_micros, is_millis, mapped;
  logic          bad_align, wr_ok;
  logic [3:0]    lanes;
  logic [31:0]   wdata;
  logic [31:0]   word;

  mmio_timebase #(.CLK_HZ(CLK_HZ)) timebase (
    .clk     (clk),
    .reset   (reset),
    .us_tick (),
    .micros  (micros),
    .millis  (millis)
  );

  initial begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) ram[i] = '0;
  end

  always_comb begin
    idx       = address[AW+1:2];
    in_ram    = (address[31:2] < 30'(MEM_WORDS));
    in_mmio   = (address[31:4] == MMIO_BASE[31:4]);
    is_led    = in_mmio && (address[3:2] == MMIO_LED[3:2]);
    is_micros = in_mmio && (address[3:2] == MMIO_MICROS[3:2]);
    is_millis = in_mmio && (address[3:2] == MMIO_MILLIS[3:2]);
    mapped    = in_ram | is_led | is_micros | is_millis;

    case (funct3)
      F3_H, F3_HU: bad_align = address[0];
      F3_W:        bad_align = (address[1:0] != 2'b00);
      default:     bad_align = 1'b0;
    endcase

    // Store data is replicated across lanes so each enabled lane takes its own slice.
    case (funct3)
      F3_B: begin
        lanes = 4'b0001 << address[1:0];
        wdata = {4{write_data[7:0]}};
      end
      F3_H: begin
        lanes = address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_data[15:0]}};
      end
      default: begin
        lanes = 4'b1111;
        wdata = write_data;
      end
    endcase

    wr_ok = write_enable && !reset && !bad_align;

    if (in_ram)         word = ram[idx];
    else if (is_led)    word = led_reg;
    else if (is_micros) word = micros;
    else if (is_millis) word = millis;
    else                word = '0;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && in_ram) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) ram[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data  <= '0;
      misaligned <= 1'b0;
      leds       <= '0;
      led_reg    <= '0;
      pwm_cnt    <= '0;
    end else begin
      read_data  <= bad_align ? '0 : load_extend(word, address[1:0], funct3);
      misaligned <= bad_align && mapped;
      pwm_cnt    <= pwm_cnt + 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
        leds[k] <= (pwm_cnt < led_reg[8*k +: PWM_BITS]);
      end
      if (wr_ok && is_led) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (lanes[i]) led_reg[8*i +: 8] <= wdata[8*i +: 8] & DUTY_MASK;
        end
      end
    end
  end

endmodule
